// File: rtl/xalu_md_pkg.sv
// Shared XALU definitions: op encoding and default latencies, used by decode,
// the stall unit and the multiply/divide unit.
package xalu_md_pkg;

    typedef logic [3:0] xalu_op_t;

    localparam xalu_op_t XALU_NONE  = 4'd0;
    localparam xalu_op_t XALU_MULT  = 4'd1;
    localparam xalu_op_t XALU_MULTU = 4'd2;
    localparam xalu_op_t XALU_DIV   = 4'd3;
    localparam xalu_op_t XALU_DIVU  = 4'd4;
    localparam xalu_op_t XALU_MTHI  = 4'd5;
    localparam xalu_op_t XALU_MTLO  = 4'd6;
    localparam xalu_op_t XALU_MFHI  = 4'd7;
    localparam xalu_op_t XALU_MFLO  = 4'd8;

    localparam int XALU_MULT_CYCLES = 5;
    localparam int XALU_DIV_CYCLES  = 10;

    // Ops that occupy the unit for several cycles.
    function automatic logic is_start_op(input xalu_op_t op);
        return (op >= XALU_MULT) && (op <= XALU_DIVU);
    endfunction

endpackage

// File: rtl/xalu_md_if.sv
// E-stage <-> multiply/divide unit bus: op and operands in, status and HI/LO out.
interface xalu_md_if;
    import xalu_md_pkg::*;

    // Handshake: an op 1..4 is accepted (Start=1) only while the unit is idle.
    // Busy stays high from that cycle until HI/LO hold the new result; the
    // stall unit keeps later XALU ops out of E while Busy is high, so no op
    // is ever presented to a busy unit except mfhi/mflo or none.
    xalu_op_t    XALUOp_E;
    logic [31:0] A;
    logic [31:0] B;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] XALUOut;

    modport master (
        output XALUOp_E, A, B,
        input  Start, Busy, HI, LO, XALUOut
    );

    modport slave (
        input  XALUOp_E, A, B,
        output Start, Busy, HI, LO, XALUOut
    );

endinterface

// File: rtl/xalu_busy_cnt.sv
// Latency countdown: loads when idle, counts to zero, and flags the edge on
// which it reaches zero so the owner can commit on that same edge.
module xalu_busy_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] count,
    output logic          done
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load && (count == '0)) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == CW'(1));

endmodule

// File: rtl/xalu_md.sv
// EX-stage multiply/divide unit owning HI/LO; results are computed at the
// start edge and committed when the latency countdown expires.
module xalu_md
    import xalu_md_pkg::*;
#(
    parameter int MULT_CYCLES = XALU_MULT_CYCLES,
    parameter int DIV_CYCLES  = XALU_DIV_CYCLES
) (
    input logic       clk,
    input logic       reset,
    xalu_md_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0]      count;
    logic [CW-1:0]      load_val;
    logic               idle;
    logic               start;
    logic               done;
    logic [31:0]        hi_q, lo_q;
    logic [31:0]        hi_pend, lo_pend;
    logic               pend_wr;
    logic [31:0]        res_hi, res_lo;
    logic               res_wr;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        div_b;
    logic               is_div;

    assign idle      = (count == '0);
    assign start     = idle && is_start_op(bus.XALUOp_E);
    assign is_div    = (bus.XALUOp_E == XALU_DIV) || (bus.XALUOp_E == XALU_DIVU);
    assign load_val  = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

    assign bus.Start = start;
    assign bus.Busy  = start || !idle;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

    assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign prod_u = {32'b0, bus.A} * {32'b0, bus.B};
    // Keep the divider's divisor nonzero; the B==0 result is never committed.
    assign div_b  = (bus.B == '0) ? 32'd1 : bus.B;

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        res_wr = 1'b1;
        case (bus.XALUOp_E)
            XALU_MULT:  {res_hi, res_lo} = prod_s;
            XALU_MULTU: {res_hi, res_lo} = prod_u;
            XALU_DIV: begin
                if (bus.B == '0) begin
                    res_wr = 1'b0;
                end else if ((bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF)) begin
                    // The one signed quotient that does not fit: wraps to the dividend.
                    res_lo = 32'h8000_0000;
                    res_hi = 32'h0;
                end else begin
                    res_lo = $signed(bus.A) / $signed(div_b);
                    res_hi = $signed(bus.A) % $signed(div_b);
                end
            end
            XALU_DIVU: begin
                if (bus.B == '0) begin
                    res_wr = 1'b0;
                end else begin
                    res_lo = bus.A / div_b;
                    res_hi = bus.A % div_b;
                end
            end
            default: res_wr = 1'b0;
        endcase
    end

    xalu_busy_cnt #(.CW(CW)) u_busy_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .load_val (load_val),
        .count    (count),
        .done     (done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            hi_pend <= '0;
            lo_pend <= '0;
            pend_wr <= 1'b0;
        end else begin
            if (start) begin
                hi_pend <= res_hi;
                lo_pend <= res_lo;
                pend_wr <= res_wr;
            end
            if (done && pend_wr) begin
                hi_q <= hi_pend;
                lo_q <= lo_pend;
            end else if (idle && (bus.XALUOp_E == XALU_MTHI)) begin
                hi_q <= bus.A;
            end else if (idle && (bus.XALUOp_E == XALU_MTLO)) begin
                lo_q <= bus.A;
            end
            assert (idle || !is_start_op(bus.XALUOp_E));
            assert (idle || !((bus.XALUOp_E == XALU_MTHI) || (bus.XALUOp_E == XALU_MTLO)));
        end
    end

    always_comb begin
        case (bus.XALUOp_E)
            XALU_MFHI: bus.XALUOut = hi_q;
            XALU_MFLO: bus.XALUOut = lo_q;
            default:   bus.XALUOut = '0;
        endcase
    end

endmodule

// File: tb/tb_xalu_md.sv
// Bench for xalu_md: directed scenarios plus random mult/div against a
// scoreboard of expected {HI,LO} values.
module tb_xalu_md;
    import xalu_md_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [63:0] exp_q[$];
    logic [63:0] m_hilo;

    xalu_md_if bus();

    xalu_md #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model of one mult/div on the given HI/LO state
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] old);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = old;
        case (op)
            XALU_MULT:  r = 64'(sa * sb);
            XALU_MULTU: r = {32'b0, a} * {32'b0, b};
            XALU_DIV:   if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
            XALU_DIVU:  if (b != 0) r = {a % b, a / b};
            default:    r = old;
        endcase
        return r;
    endfunction

    // driver: one mthi/mtlo write
    task automatic drive_mt(input logic [3:0] op, input logic [31:0] a);
        @(posedge clk); #1;
        bus.XALUOp_E = op;
        bus.A        = a;
        @(posedge clk); #1;
        bus.XALUOp_E = XALU_NONE;
    endtask

    // driver: issue a mult/div, hold 'hold' in E while busy, stop at first idle cycle
    task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] hold, output int busy_n, output logic held_ok,
                            output logic [31:0] hi_o, output logic [31:0] lo_o,
                            output logic [31:0] xout);
        logic [31:0] h0, l0;
        @(posedge clk); #1;
        h0 = bus.HI;
        l0 = bus.LO;
        bus.XALUOp_E = op;
        bus.A        = a;
        bus.B        = b;
        busy_n       = 0;
        held_ok      = 1'b1;
        #1;
        while (bus.Busy && busy_n < 40) begin
            busy_n++;
            if (bus.HI !== h0 || bus.LO !== l0) held_ok = 1'b0;
            @(posedge clk); #1;
            bus.XALUOp_E = hold;
            bus.A        = $urandom;
            bus.B        = $urandom;
            #1;
        end
        hi_o = bus.HI;
        lo_o = bus.LO;
        xout = bus.XALUOut;
        bus.XALUOp_E = XALU_NONE;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.XALUOp_E = XALU_NONE;
        bus.A = '0;
        bus.B = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.XALUOp_E = XALU_MFHI;
        #1;
        total++; if (bus.HI !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", bus.HI, 32'h0); end
        total++; if (bus.LO !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", bus.LO, 32'h0); end
        total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
        total++; if (bus.XALUOut !== 32'h0) begin bad++; $display("FAIL reset_xout got=%h exp=0", bus.XALUOut); end
        bus.XALUOp_E = XALU_NONE;
        m_hilo = '0;
    endtask

    task automatic test_multu;
        int busy_n; logic held; logic [31:0] h, l, x; logic [63:0] e;
        exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
        drive_op(XALU_MULTU, 32'hFFFF_FFFF, 32'd2, XALU_NONE, busy_n, held, h, l, x);
        e = exp_q.pop_front();
        total++; if (busy_n != 6) begin bad++; $display("FAIL multu_busy got=%0d exp=6", busy_n); end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL multu_hold got=%b exp=1", held); end
        total++; if ({h, l} !== e) begin bad++; $display("FAIL multu_result got=%h exp=%h", {h, l}, e); end
        m_hilo = e;
    endtask

    task automatic test_mult_div;
        int busy_n; logic held; logic [31:0] h, l, x; logic [63:0] e;
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
        drive_op(XALU_MULT, -32'sd3, 32'sd7, XALU_NONE, busy_n, held, h, l, x);
        e = exp_q.pop_front();
        total++; if (busy_n != 6) begin bad++; $display("FAIL mult_busy got=%0d exp=6", busy_n); end
        total++; if ({h, l} !== e) begin bad++; $display("FAIL mult_result got=%h exp=%h", {h, l}, e); end
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        drive_op(XALU_DIV, -32'sd7, 32'sd2, XALU_NONE, busy_n, held, h, l, x);
        e = exp_q.pop_front();
        total++; if (busy_n != 11) begin bad++; $display("FAIL div_busy got=%0d exp=11", busy_n); end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL div_hold got=%b exp=1", held); end
        total++; if ({h, l} !== e) begin bad++; $display("FAIL div_result got=%h exp=%h", {h, l}, e); end
        m_hilo = e;
    endtask

    task automatic test_div_zero_mthi;
        int busy_n; logic held; logic [31:0] h, l, x; logic [63:0] e;
        drive_mt(XALU_MTHI, 32'h11);
        drive_mt(XALU_MTLO, 32'h22);
        total++; if ({bus.HI, bus.LO} !== {32'h11, 32'h22}) begin
            bad++; $display("FAIL preset_hilo got=%h exp=%h", {bus.HI, bus.LO}, {32'h11, 32'h22});
        end
        exp_q.push_back({32'h11, 32'h22});
        drive_op(XALU_DIV, 32'd1234, 32'd0, XALU_NONE, busy_n, held, h, l, x);
        e = exp_q.pop_front();
        total++; if (busy_n != 11) begin bad++; $display("FAIL div0_busy got=%0d exp=11", busy_n); end
        total++; if ({h, l} !== e) begin bad++; $display("FAIL div0_result got=%h exp=%h", {h, l}, e); end
        @(posedge clk); #1;
        bus.XALUOp_E = XALU_MTHI;
        bus.A        = 32'h5;
        #1;
        total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b exp=0", bus.Busy); end
        @(posedge clk); #1;
        bus.XALUOp_E = XALU_NONE;
        #1;
        total++; if (bus.HI !== 32'h5) begin bad++; $display("FAIL mthi_hi got=%h exp=%h", bus.HI, 32'h5); end
        total++; if (bus.LO !== 32'h22) begin bad++; $display("FAIL mthi_lo got=%h exp=%h", bus.LO, 32'h22); end
    endtask

    task automatic test_reset_mid_op;
        drive_mt(XALU_MTHI, 32'hAA);
        drive_mt(XALU_MTLO, 32'hBB);
        @(posedge clk); #1;
        bus.XALUOp_E = XALU_DIV;
        bus.A        = 32'd100;
        bus.B        = 32'd7;
        repeat (3) begin
            @(posedge clk); #1;
            bus.XALUOp_E = XALU_NONE;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        total++; if ({bus.HI, bus.LO} !== 64'h0) begin bad++; $display("FAIL rstmid_hilo got=%h exp=0", {bus.HI, bus.LO}); end
        total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.Busy); end
        repeat (8) @(posedge clk);
        #1;
        total++; if ({bus.HI, bus.LO} !== 64'h0) begin bad++; $display("FAIL rstmid_late got=%h exp=0", {bus.HI, bus.LO}); end
        total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL rstmid_late_busy got=%b exp=0", bus.Busy); end
        m_hilo = '0;
    endtask

    task automatic test_back_to_back;
        int busy_n; logic held; logic [31:0] h, l, x; logic [63:0] e;
        exp_q.push_back({32'h0000_0001, 32'h2345_6780});
        drive_op(XALU_MULT, 32'h1234_5678, 32'h10, XALU_MFLO, busy_n, held, h, l, x);
        e = exp_q.pop_front();
        total++; if (busy_n != 6) begin bad++; $display("FAIL b2b_busy got=%0d exp=6", busy_n); end
        total++; if (x !== e[31:0]) begin bad++; $display("FAIL b2b_mflo got=%h exp=%h", x, e[31:0]); end
        exp_q.push_back({32'h0, 32'h8000_0000});
        drive_op(XALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, XALU_MFHI, busy_n, held, h, l, x);
        e = exp_q.pop_front();
        total++; if ({h, l} !== e) begin bad++; $display("FAIL b2b_ovf got=%h exp=%h", {h, l}, e); end
        total++; if (x !== e[63:32]) begin bad++; $display("FAIL b2b_mfhi got=%h exp=%h", x, e[63:32]); end
        m_hilo = e;
    endtask

    task automatic test_random;
        int busy_n, exp_n; logic held; logic [31:0] h, l, x, a, b; logic [3:0] op; logic [63:0] e;
        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(1, 4));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
            exp_n  = (op <= XALU_MULTU) ? 6 : 11;
            m_hilo = model(op, a, b, m_hilo);
            exp_q.push_back(m_hilo);
            drive_op(op, a, b, XALU_NONE, busy_n, held, h, l, x);
            e = exp_q.pop_front();
            total++; if (busy_n != exp_n) begin bad++; $display("FAIL rnd_busy op=%0d got=%0d exp=%0d", op, busy_n, exp_n); end
            total++; if ({h, l} !== e) begin
                bad++; $display("FAIL rnd_result op=%0d a=%h b=%h got=%h exp=%h", op, a, b, {h, l}, e);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_multu();
        test_mult_div();
        test_div_zero_mthi();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_empty got=%0d exp=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
